pixel_draw_sequencer: RTL and testbench

//  Sits between the pixel sources and the vga_adapter write port. After reset it

---
 rtl/draw_pkg.sv | 25 ++
 rtl/pixel_out_reg.sv | 79 +++++++
 rtl/pixel_draw_sequencer.sv | 121 ++++++++++++
 tb/tb_pixel_draw_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the pixel draw path: FSM states, screen
// geometry, coordinate/colour widths and the saturating pixel counter helper.
package draw_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_CLEAR = 2'd1,
        S_GAME  = 2'd2
    } state_t;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int XW       = 9;
    localparam int YW       = 8;
    localparam int CW       = 3;
    localparam int CNTW     = 17;

    localparam logic [CW-1:0] WHITE = 3'b111;
    localparam logic [CW-1:0] BLACK = 3'b000;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == '1) ? v : v + CNTW'(1);
    endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// Registered x/y/colour/plot stage feeding the vga_adapter write port.
// With BOUNDS_CHECK_EN defined, off-screen pixels are swallowed and flagged.
module pixel_out_reg #(
    parameter int XW = draw_pkg::XW,
    parameter int YW = draw_pkg::YW,
    parameter int CW = draw_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [CW-1:0] i_colour,
`ifdef BOUNDS_CHECK_EN
    input  logic          i_oob_clr,
    output logic          o_oob_seen,
`endif
    output logic          o_in_range,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [CW-1:0] o_colour,
    output logic          o_plot
);

    logic [XW-1:0] r_x_p1;
    logic [YW-1:0] r_y_p1;
    logic [CW-1:0] r_colour_p1;
    logic          r_plot_p1;
    logic          w_plot;

`ifdef BOUNDS_CHECK_EN
    localparam logic [XW-1:0] X_LIM = XW'(draw_pkg::SCREEN_W);
    localparam logic [YW-1:0] Y_LIM = YW'(draw_pkg::SCREEN_H);

    logic r_oob_seen;

    assign o_in_range = (i_x < X_LIM) && (i_y < Y_LIM);

    // Sticky until the next restart; restart has priority over a new violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oob_seen <= 1'b0;
        end else if (i_oob_clr) begin
            r_oob_seen <= 1'b0;
        end else if (i_load && !o_in_range) begin
            r_oob_seen <= 1'b1;
        end
    end

    assign o_oob_seen = r_oob_seen;
`else
    assign o_in_range = 1'b1;
`endif

    assign w_plot = i_load && o_in_range;

    // Output stage boundary: data holds its last value whenever nothing is plotted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_p1      <= '0;
            r_y_p1      <= '0;
            r_colour_p1 <= '0;
            r_plot_p1   <= 1'b0;
        end else begin
            r_plot_p1 <= w_plot;
            if (w_plot) begin
                r_x_p1      <= i_x;
                r_y_p1      <= i_y;
                r_colour_p1 <= i_colour;
            end
        end
    end

    assign o_x      = r_x_p1;
    assign o_y      = r_y_p1;
    assign o_colour = r_colour_p1;
    assign o_plot   = r_plot_p1;

endmodule

// File: rtl/pixel_draw_sequencer.sv
// Arbitrates the vga_adapter write port: screen clear after reset/restart, then
// the game drawer. Optional BOUNDS_CHECK_EN drops off-screen pixels (oob_seen).
module pixel_draw_sequencer #(
    parameter int XW = draw_pkg::XW,
    parameter int YW = draw_pkg::YW,
    parameter int CW = draw_pkg::CW
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      game_restart,
    output logic                      clear_start,
    input  logic [XW-1:0]             clr_x,
    input  logic [YW-1:0]             clr_y,
    input  logic [CW-1:0]             clr_colour,
    input  logic                      clr_valid,
    input  logic                      clr_done,
    input  logic [XW-1:0]             game_x,
    input  logic [YW-1:0]             game_y,
    input  logic [CW-1:0]             game_colour,
    input  logic                      game_valid,
    output logic                      game_ready,
    output logic [XW-1:0]             vga_x,
    output logic [YW-1:0]             vga_y,
    output logic [CW-1:0]             vga_colour,
    output logic                      vga_plot,
    output logic                      clearing,
    output logic [draw_pkg::CNTW-1:0] clr_count
`ifdef BOUNDS_CHECK_EN
    ,
    output logic                      oob_seen
`endif
);

    import draw_pkg::*;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_clr_count;
    logic            w_clr_acc;
    logic            w_game_acc;
    logic            w_load;
    logic            w_in_range;
    logic [XW-1:0]   w_x;
    logic [YW-1:0]   w_y;
    logic [CW-1:0]   w_colour;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START: w_next = S_CLEAR;
            S_CLEAR: if (clr_done) w_next = S_GAME;
            S_GAME:  w_next = S_GAME;
            default: w_next = S_START;
        endcase
        if (game_restart) begin
            w_next = S_START;
        end
    end

    // Gated by resetn so every output reads 0 while reset is held.
    always_comb begin
        clear_start = 1'b0;
        clearing    = 1'b0;
        game_ready  = 1'b0;
        if (resetn) begin
            clear_start = (r_state == S_START);
            clearing    = (r_state != S_GAME);
            game_ready  = (r_state == S_GAME);
        end
    end

    assign w_clr_acc  = (r_state == S_CLEAR) && clr_valid;
    assign w_game_acc = game_ready && game_valid;
    assign w_load     = w_clr_acc || w_game_acc;
    assign w_x        = w_clr_acc ? clr_x      : game_x;
    assign w_y        = w_clr_acc ? clr_y      : game_y;
    assign w_colour   = w_clr_acc ? clr_colour : game_colour;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clr_count <= '0;
        end else if (r_state == S_START) begin
            r_clr_count <= '0;
        end else if (w_clr_acc && w_in_range) begin
            r_clr_count <= sat_inc(r_clr_count);
        end
    end

    assign clr_count = r_clr_count;

    pixel_out_reg #(
        .XW(XW),
        .YW(YW),
        .CW(CW)
    ) u_out (
        .clk       (clock),
        .rst_n     (resetn),
        .i_load    (w_load),
        .i_x       (w_x),
        .i_y       (w_y),
        .i_colour  (w_colour),
`ifdef BOUNDS_CHECK_EN
        .i_oob_clr (game_restart),
        .o_oob_seen(oob_seen),
`endif
        .o_in_range(w_in_range),
        .o_x       (vga_x),
        .o_y       (vga_y),
        .o_colour  (vga_colour),
        .o_plot    (vga_plot)
    );

endmodule

// File: tb/tb_pixel_draw_sequencer.sv
// Self-checking bench for pixel_draw_sequencer: per-cycle behavioural model plus
// directed scenarios with literal expectations. Honours BOUNDS_CHECK_EN.
module tb_pixel_draw_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        game_restart;
    logic        clear_start;
    logic [8:0]  clr_x;
    logic [7:0]  clr_y;
    logic [2:0]  clr_colour;
    logic        clr_valid;
    logic        clr_done;
    logic [8:0]  game_x;
    logic [7:0]  game_y;
    logic [2:0]  game_colour;
    logic        game_valid;
    logic        game_ready;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clearing;
    logic [16:0] clr_count;
`ifdef BOUNDS_CHECK_EN
    logic        oob_seen;
`endif

    pixel_draw_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .game_restart(game_restart),
        .clear_start (clear_start),
        .clr_x       (clr_x),
        .clr_y       (clr_y),
        .clr_colour  (clr_colour),
        .clr_valid   (clr_valid),
        .clr_done    (clr_done),
        .game_x      (game_x),
        .game_y      (game_y),
        .game_colour (game_colour),
        .game_valid  (game_valid),
        .game_ready  (game_ready),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clearing    (clearing),
`ifdef BOUNDS_CHECK_EN
        .clr_count   (clr_count),
        .oob_seen    (oob_seen)
`else
        .clr_count   (clr_count)
`endif
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_plots = 0;
    int n_cs    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: phase 0 = clearing kick-off, 1 = clearing, 2 = game.
    int m_phase, m_plot, m_x, m_y, m_col, m_cnt, m_oob;

    function automatic int on_screen(input int x, input int y);
`ifdef BOUNDS_CHECK_EN
        return (x < 320 && y < 240) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0; m_plot = 0; m_x = 0; m_y = 0; m_col = 0; m_cnt = 0; m_oob = 0;
        end else begin
            int acc_c, acc_g, px, py, pc, ok;
            acc_c = (m_phase == 1 && clr_valid) ? 1 : 0;
            acc_g = (m_phase == 2 && game_valid) ? 1 : 0;
            px = acc_c ? int'(clr_x) : int'(game_x);
            py = acc_c ? int'(clr_y) : int'(game_y);
            pc = acc_c ? int'(clr_colour) : int'(game_colour);
            ok = on_screen(px, py);
            m_plot = ((acc_c || acc_g) && ok) ? 1 : 0;
            if (m_plot == 1) begin m_x = px; m_y = py; m_col = pc; end
            if (m_phase == 0) m_cnt = 0;
            else if (acc_c && ok && m_cnt < 131071) m_cnt = m_cnt + 1;
            if (game_restart) m_oob = 0;
            else if ((acc_c || acc_g) && !ok) m_oob = 1;
            if (game_restart) m_phase = 0;
            else if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && clr_done) m_phase = 2;
        end
    end

    always @(negedge clock) begin
        int e_cs, e_clr, e_rdy;
        e_cs  = (resetn && m_phase == 0) ? 1 : 0;
        e_clr = (resetn && m_phase != 2) ? 1 : 0;
        e_rdy = (resetn && m_phase == 2) ? 1 : 0;
        check("clear_start", int'(clear_start), e_cs);
        check("clearing", int'(clearing), e_clr);
        check("game_ready", int'(game_ready), e_rdy);
        check("vga_plot", int'(vga_plot), m_plot);
        check("vga_x", int'(vga_x), m_x);
        check("vga_y", int'(vga_y), m_y);
        check("vga_colour", int'(vga_colour), m_col);
        check("clr_count", int'(clr_count), m_cnt);
`ifdef BOUNDS_CHECK_EN
        check("oob_seen", int'(oob_seen), m_oob);
`endif
        if (vga_plot) n_plots++;
        if (clear_start) n_cs++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        game_restart = 0; clr_valid = 0; clr_done = 0; game_valid = 0;
    endtask

    initial begin
        resetn = 0; game_restart = 0;
        clr_x = 0; clr_y = 0; clr_colour = 0; clr_valid = 0; clr_done = 0;
        game_x = 0; game_y = 0; game_colour = 0; game_valid = 0;
        repeat (3) step();
        check("rst_clear_start", int'(clear_start), 0);
        check("rst_clearing", int'(clearing), 0);
        check("rst_vga_plot", int'(vga_plot), 0);
        check("rst_clr_count", int'(clr_count), 0);

        // Release: one S_START cycle, then clearing.
        resetn = 1;
        #2;
        check("start_pulse", int'(clear_start), 1);
        check("start_clearing", int'(clearing), 1);
        check("start_ready", int'(game_ready), 0);
        step();
        check("start_done", int'(clear_start), 0);

        // 80 clear pixels; game source pushes meanwhile and must be ignored.
        for (int i = 0; i < 80; i++) begin
            clr_valid = 1; clr_x = 9'(i % 20); clr_y = 8'(i / 20); clr_colour = 3'(i);
            game_valid = (i < 10); game_x = 9'd100; game_y = 8'd100; game_colour = 3'd5;
            if (i == 5) check("ready_in_clear", int'(game_ready), 0);
            step();
        end
        idle_inputs();
        clr_done = 1;
        step();
        clr_done = 0;
        check("clear_plots", n_plots, 80);
        check("clear_count", int'(clr_count), 80);
        check("game_ready_after", int'(game_ready), 1);

        // Five back-to-back game pixels.
        for (int k = 0; k < 5; k++) begin
            game_valid = 1; game_x = 9'(10 + k); game_y = 8'd3; game_colour = 3'b100;
            step();
            check("game_plot_b2b", int'(vga_plot), 1);
            check("game_x_b2b", int'(vga_x), 10 + k);
        end
        game_valid = 0;
        clr_valid = 1; clr_x = 9'd1; clr_y = 8'd1; clr_colour = 3'd7;
        step();
        clr_valid = 0;
        step();
        check("game_plots", n_plots, 85);
        check("hold_x", int'(vga_x), 14);
        check("hold_y", int'(vga_y), 3);
        check("hold_colour", int'(vga_colour), 4);

        // Restart from game, then restart together with clr_done.
        game_restart = 1;
        step();
        game_restart = 0;
        check("restart_start", int'(clear_start), 1);
        check("restart_cnt_kept", int'(clr_count), 80);
        step();
        check("restart_cnt_zero", int'(clr_count), 0);
        for (int i = 0; i < 3; i++) begin
            clr_valid = 1; clr_x = 9'(50 + i); clr_y = 8'd9; clr_colour = 3'd2;
            clr_done = (i == 2); game_restart = (i == 2);
            step();
        end
        idle_inputs();
        check("restart_wins", int'(clear_start), 1);
        check("restart_wins_cnt", int'(clr_count), 3);
        check("restart_wins_px", int'(vga_x), 52);
        game_restart = 1;
        step();
        game_restart = 0;
        check("restart_in_start", int'(clear_start), 1);
        check("restart_in_start_cnt", int'(clr_count), 0);
        step();
        check("cs_pulses", n_cs, 4);

        // Pixel alongside clr_done is still forwarded.
        clr_valid = 1; clr_x = 9'd300; clr_y = 8'd200; clr_colour = draw_pkg::WHITE; clr_done = 1;
        step();
        idle_inputs();
        check("done_px_plot", int'(vga_plot), 1);
        check("done_px_x", int'(vga_x), 300);
        check("done_px_cnt", int'(clr_count), 1);
        check("done_ready", int'(game_ready), 1);

        // Off-screen game pixels.
        game_valid = 1; game_x = 9'd320; game_y = 8'd5; game_colour = 3'd1;
        check("oob_handshake", int'(game_ready), 1);
        step();
`ifdef BOUNDS_CHECK_EN
        check("oob_no_plot", int'(vga_plot), 0);
        check("oob_flag", int'(oob_seen), 1);
`else
        check("wide_plot", int'(vga_plot), 1);
        check("wide_x", int'(vga_x), 320);
`endif
        game_x = 9'd5; game_y = 8'd240;
        step();
        game_x = 9'd319; game_y = 8'd239; game_colour = 3'd6;
        step();
        game_valid = 0;
        check("edge_px_plot", int'(vga_plot), 1);
        check("edge_px_x", int'(vga_x), 319);
        game_restart = 1;
        step();
        game_restart = 0;
        step();
        clr_valid = 1; clr_x = 9'd0; clr_y = 8'd240; clr_colour = draw_pkg::BLACK;
        step();
        clr_x = 9'd2; clr_y = 8'd2; clr_done = 1;
        step();
        idle_inputs();
`ifdef BOUNDS_CHECK_EN
        check("oob_clr_cnt", int'(clr_count), 1);
        check("oob_cleared", int'(oob_seen), 1);
`else
        check("all_clr_cnt", int'(clr_count), 2);
`endif

        // Asynchronous reset mid-game with a pixel in flight.
        game_valid = 1; game_x = 9'd7; game_y = 8'd7; game_colour = 3'd3;
        step();
        check("pre_rst_plot", int'(vga_plot), 1);
        #2;
        resetn = 0;
        #1;
        check("async_plot", int'(vga_plot), 0);
        check("async_ready", int'(game_ready), 0);
        check("async_cnt", int'(clr_count), 0);
        check("async_x", int'(vga_x), 0);
        game_valid = 0;
        repeat (2) step();
        resetn = 1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
